alu_result_stage: RTL
=====================

# alu_result_stage

Registered output stage for the 32-bit ALU datapath: it consumes the combinational result of the ALU function units (AND, OR, ADD, …) through a valid/ready handshake and holds it for the downstream consumer (register-file writeback or testbench monitor). A two-entry skid buffer gives full throughput with a registered `in_ready`. Optional status flags are computed on the registered result.

## Interface
- `WIDTH`, default 32: data width of the ALU result.
- `CNT_W`, default 16: width of the delivered-result counter.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  upstream ALU result is valid.
- `in_ready`  output  1  stage can accept a result (registered).
- `in_result`  input  WIDTH  ALU result word.
- `out_valid`  output  1  `out_result` holds a result.
- `out_ready`  input  1  downstream accepts the result.
- `out_result`  output  WIDTH  oldest buffered result.
- `out_zero`  output  1  `out_result == 0` (flag build only).
- `out_neg`  output  1  `out_result[WIDTH-1]` (flag build only).
- `out_count`  output  CNT_W  number of results delivered since reset, modulo 2^CNT_W.

## Operation
- Accept on `in_valid && in_ready`; deliver on `out_valid && out_ready`.
- Storage: a main register drives `out_*`; a skid register holds one extra result.
- States:
  - EMPTY: `out_valid=0`, `in_ready=1`.
  - ONE: main valid, skid empty, `in_ready=1`.
  - FULL: both valid, `in_ready=0`.
- Transitions:
  - EMPTY + accept → ONE, with data to main.
  - ONE + accept, no deliver → FULL, with data to skid.
  - ONE + deliver, no accept → EMPTY.
  - ONE + accept and deliver → ONE, with new data to main.
  - FULL + deliver → ONE, with skid moving to main.
  - FULL cannot accept because `in_ready=0`.
  - All other cases hold state.
- Results are delivered strictly in order. None are dropped or duplicated.
- `out_count` increments by 1 on each deliver and wraps from 2^CNT_W−1 to 0.
- Upstream must hold `in_result` stable while `in_valid && !in_ready`. The stage never samples it in that cycle.
- `out_result` and the flags stay stable while `out_valid && !out_ready`.

## Timing
- Latency: 1 cycle. A result accepted at edge N is on `out_result` with `out_valid=1` after edge N.
- Throughput: 1 result per cycle when `out_ready` is held high.
- `in_ready` comes directly from a flop, with no combinational path from `out_ready`. It falls the cycle after the stage enters FULL and rises the cycle after it leaves FULL.
- Reset values (async, effective immediately while `rst=1`):
  - `out_valid=0`, `in_ready=1`.
  - `out_result=0`, `out_zero=0`, `out_neg=0`, `out_count=0`.
  - State EMPTY, skid invalid.
- Reset mid-operation discards both buffered entries. No deliver is counted for the reset cycle.
- Simultaneous accept and deliver in ONE keeps `out_valid` high with no bubble.

## Configuration
- `ALU_RESULT_FLAGS_EN` defined:
  - `out_zero` and `out_neg` are computed from the incoming word and stored alongside it in both main and skid.
  - They are valid with `out_result`.
- `ALU_RESULT_FLAGS_EN` undefined:
  - Both flag ports are still present and tied to 0.
  - No flag storage is built.
- Data path, handshake and counter behave identically in both builds.

## Test plan
- Reset, then a single push of `in_result=32'h0000_00F0` with `out_ready=1`:
  - one cycle later `out_valid=1`, `out_result=32'h0000_00F0`, `out_zero=0`, `out_neg=0`;
  - `out_count` becomes 1 after the deliver.
- Stall: `out_ready=0`, push 5 then 7 on consecutive cycles:
  - `in_ready` drops to 0 after the second accept;
  - a third push with `in_valid=1` is not taken;
  - after raising `out_ready`, 5 then 7 emerge and `in_ready` returns to 1.
- Streaming: 100 back-to-back pushes of values 0..99 with `out_ready=1`:
  - outputs are 0..99 in order, one per cycle with no bubbles;
  - `out_count=100`;
  - with flags built, `out_zero=1` only for the value 0.
- Flags: push `32'h8000_0000`, then `32'h0`:
  - the first gives `out_neg=1`, `out_zero=0`;
  - the second gives `out_neg=0`, `out_zero=1`;
  - without `ALU_RESULT_FLAGS_EN`, both flags read 0.
- Async reset asserted while FULL with `out_ready=0`:
  - `out_valid` goes to 0 and `in_ready` to 1 without waiting for a clock edge;
  - `out_count` goes to 0;
  - after release, the next push appears with latency 1.
- Counter wrap with `CNT_W=4`: 17 delivers leave `out_count=1`.

Source files
------------

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU function units, the result stage and its consumer.
// The stage side uses the slave modport; upstream/downstream logic uses master.
interface alu_result_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_neg;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid,
    input  in_result,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result,
    output out_zero,
    output out_neg,
    output out_count
  );

  modport master (
    output in_valid,
    output in_result,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result,
    input  out_zero,
    input  out_neg,
    input  out_count
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: two-entry skid buffer with registered in_ready and a delivery counter.
// Define ALU_RESULT_FLAGS_EN to build zero/negative flag storage alongside each buffered result.
module alu_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_result_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] count_q;

  logic accept_c;
  logic deliver_c;

  assign accept_c  = bus.in_valid && in_ready_q;
  assign deliver_c = out_valid_q && bus.out_ready;

  // Buffer control: main register always feeds the output, skid catches one extra result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            main_q      <= bus.in_result;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept_c && deliver_c) begin
            main_q <= bus.in_result;
          end else if (accept_c) begin
            skid_q     <= bus.in_result;
            in_ready_q <= 1'b0;
            state_q    <= ST_FULL;
          end else if (deliver_c) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (deliver_c) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (deliver_c) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

`ifdef ALU_RESULT_FLAGS_EN
  logic main_zero_q;
  logic main_neg_q;
  logic skid_zero_q;
  logic skid_neg_q;
  logic in_zero_c;
  logic in_neg_c;

  assign in_zero_c = (bus.in_result == '0);
  assign in_neg_c  = bus.in_result[WIDTH-1];

  // Flags follow exactly the same load pattern as the data registers above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_zero_q <= 1'b0;
      main_neg_q  <= 1'b0;
      skid_zero_q <= 1'b0;
      skid_neg_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            main_zero_q <= in_zero_c;
            main_neg_q  <= in_neg_c;
          end
        end
        ST_ONE: begin
          if (accept_c && deliver_c) begin
            main_zero_q <= in_zero_c;
            main_neg_q  <= in_neg_c;
          end else if (accept_c) begin
            skid_zero_q <= in_zero_c;
            skid_neg_q  <= in_neg_c;
          end
        end
        ST_FULL: begin
          if (deliver_c) begin
            main_zero_q <= skid_zero_q;
            main_neg_q  <= skid_neg_q;
          end
        end
        default: begin
          main_zero_q <= 1'b0;
          main_neg_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_zero = main_zero_q;
  assign bus.out_neg  = main_neg_q;
`else
  assign bus.out_zero = 1'b0;
  assign bus.out_neg  = 1'b0;
`endif

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = main_q;
  assign bus.out_count  = count_q;

endmodule
